// File: rtl/rs_gf_pkg.sv
// rs_gf_pkg: GF(2^M) arithmetic and shared types for the
// single-error Reed-Solomon stream decoder.
package rs_gf_pkg;
  localparam int M_DEF = 3;
  localparam int N = 2**M_DEF - 1;
  localparam int K = N - 2;
  localparam int MW = 8;

  typedef logic [M_DEF-1:0] sym_t;
  typedef logic [MW-1:0] gfw_t;
  typedef logic [MW:0] gfp_t;

  localparam gfw_t ALPHA = 8'd2;
  localparam gfw_t ALPHA2 = 8'd4;

  typedef enum logic [1:0] {
    CLEAN,
    CORRECTED,
    UNCORRECTABLE
  } status_t;

  typedef enum logic {
    COLLECT,
    SOLVE
  } fsm_t;

  function automatic gfw_t gf_mul(
    input gfw_t a,
    input gfw_t b,
    input int m,
    input gfp_t poly
  );
    gfp_t acc;
    gfp_t sh;
    acc = '0;
    sh = {1'b0, a};
    for (int i = 0; i < MW; i++) begin
      if (i < m) begin
        if (b[i]) acc = acc ^ sh;
        sh = sh << 1;
        if (sh[m]) sh = sh ^ poly;
      end
    end
    return acc[MW-1:0];
  endfunction

  function automatic gfw_t gf_inv(
    input gfw_t a,
    input int m,
    input gfp_t poly
  );
    gfw_t r;
    r = '0;
    for (int i = 1; i < 2**MW; i++) begin
      if (i < (1 << m)) begin
        if (gf_mul(a, gfw_t'(i), m, poly) == gfw_t'(1))
          r = gfw_t'(i);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/rs_syndrome_acc.sv
// rs_syndrome_acc: Horner accumulators for S1 = r(alpha)
// and S2 = r(alpha^2), one received symbol per enable.
module rs_syndrome_acc
  import rs_gf_pkg::*;
#(
  parameter int M = 3,
  parameter logic [M:0] PRIM_POLY = 4'b1011
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [M-1:0] sym,
  output logic [M-1:0] s1,
  output logic [M-1:0] s2,
  output logic [M-1:0] s1_next,
  output logic [M-1:0] s2_next
);
  localparam gfp_t POLY = gfp_t'(PRIM_POLY);

  // accumulator values with the current symbol folded in
  always_comb begin
    s1_next = M'(gf_mul(gfw_t'(s1), ALPHA, M, POLY)) ^ sym;
    s2_next = M'(gf_mul(gfw_t'(s2), ALPHA2, M, POLY)) ^ sym;
  end

  // clear wins so the codeword's last symbol leaves both at zero
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      s1 <= '0;
      s2 <= '0;
    end else if (en) begin
      s1 <= s1_next;
      s2 <= s2_next;
    end
  end
endmodule

// File: rtl/rs_t1_stream_decoder.sv
// rs_t1_stream_decoder: symbol-serial RS(N,N-2) decoder with
// ping-pong codeword banks and single-symbol correction.
module rs_t1_stream_decoder
  import rs_gf_pkg::*;
#(
  parameter int M = 3,
  parameter logic [M:0] PRIM_POLY = 4'b1011
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_sym,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_sym,
  output logic         out_last,
  output logic         out_corrected,
  output logic         out_uncorrectable
);
  localparam int LEN = 2**M - 1;
  localparam gfp_t POLY = gfp_t'(PRIM_POLY);
  typedef logic [M-1:0] word_t;
  localparam word_t LAST = word_t'(LEN - 1);
  localparam word_t ONE = word_t'(1);
  localparam word_t ALPHA_W = word_t'(ALPHA);

  function automatic word_t mul(input word_t a, input word_t b);
    return word_t'(gf_mul(gfw_t'(a), gfw_t'(b), M, POLY));
  endfunction

  word_t inv_tab [2**M];
  for (genvar i = 0; i < 2**M; i++) begin : g_inv
    localparam gfw_t V = gf_inv(gfw_t'(i), M, POLY);
    assign inv_tab[i] = word_t'(V);
  end

  fsm_t    state, state_nx;
  word_t   mem [2][LEN];
  word_t   bank_x [2];
  word_t   bank_e [2];
  status_t bank_st [2];
  logic [1:0] full, set_m, clr_m;
  logic    wp, rp, active;
  word_t   cnt, oc, q;
  word_t   s1, s2, s1_nx, s2_nx, syn1, syn2;
  word_t   x_sol, e_sol;
  status_t st_sol;
  logic    in_fire, out_fire, last_in, last_out;

  assign in_ready = (state == COLLECT) && !full[wp];
  assign in_fire = in_valid && in_ready;
  assign last_in = in_fire && (cnt == LAST);
  assign out_valid = active;
  assign out_fire = active && out_ready;
  assign last_out = out_fire && (oc == LAST);

  rs_syndrome_acc #(
    .M(M),
    .PRIM_POLY(PRIM_POLY)
  ) u_syn (
    .clk(clk),
    .reset(reset),
    .clr(last_in),
    .en(in_fire),
    .sym(in_sym),
    .s1(s1),
    .s2(s2),
    .s1_next(s1_nx),
    .s2_next(s2_nx)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= COLLECT;
    else state <= state_nx;
  end

  // one SOLVE cycle after each complete codeword
  always_comb begin
    state_nx = state;
    unique case (state)
      COLLECT: if (last_in) state_nx = SOLVE;
      SOLVE:   state_nx = COLLECT;
    endcase
  end

  // error locator, magnitude and classification
  always_comb begin
    x_sol = mul(syn2, inv_tab[syn1]);
    e_sol = mul(mul(syn1, syn1), inv_tab[syn2]);
    st_sol = CLEAN;
    if (syn1 != '0 && syn2 != '0) st_sol = CORRECTED;
    else if (syn1 != '0 || syn2 != '0) st_sol = UNCORRECTABLE;
  end

  // bank occupancy updates from solver and drain
  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (state == SOLVE) set_m[wp] = 1'b1;
    if (last_out) clr_m[rp] = 1'b1;
  end

  // codeword storage and per-bank decode results
  always_ff @(posedge clk) begin
    if (in_fire) mem[wp][cnt] <= in_sym;
    if (state == SOLVE) begin
      bank_x[wp] <= x_sol;
      bank_e[wp] <= e_sol;
      bank_st[wp] <= st_sol;
    end
  end

  // fill/drain pointers, counters and position register
  always_ff @(posedge clk) begin
    if (!reset) begin
      full <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= '0;
      syn1 <= '0;
      syn2 <= '0;
      active <= 1'b0;
      oc <= '0;
      q <= '0;
    end else begin
      full <= (full | set_m) & ~clr_m;
      if (in_fire) cnt <= last_in ? '0 : cnt + ONE;
      if (last_in) begin
        syn1 <= s1_nx;
        syn2 <= s2_nx;
      end
      if (state == SOLVE) wp <= ~wp;
      if (!active && full[rp]) begin
        active <= 1'b1;
        oc <= '0;
        q <= mul(bank_x[rp], ALPHA_W);
      end else if (out_fire) begin
        q <= mul(q, ALPHA_W);
        oc <= oc + ONE;
        if (last_out) begin
          active <= 1'b0;
          rp <= ~rp;
        end
      end
    end
  end

  // output symbol with the located error cancelled
  always_comb begin
    out_sym = '0;
    out_last = 1'b0;
    out_corrected = 1'b0;
    out_uncorrectable = 1'b0;
    if (active) begin
      out_sym = mem[rp][oc];
      if (bank_st[rp] == CORRECTED && q == ONE)
        out_sym = out_sym ^ bank_e[rp];
      out_last = (oc == LAST);
      out_corrected = (bank_st[rp] == CORRECTED);
      out_uncorrectable = (bank_st[rp] == UNCORRECTABLE);
    end
  end
endmodule

// File: tb/tb_rs_t1_stream_decoder.sv
// tb_rs_t1_stream_decoder: directed RS(7,5) vectors with a
// queue scoreboard and an independent output monitor.
module tb_rs_t1_stream_decoder;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_sym = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_sym;
  logic       out_last;
  logic       out_corrected;
  logic       out_uncorrectable;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;
  logic [5:0] exp_q [$];

  localparam logic [20:0] CLEAN_W =
    {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd6, 3'd3};
  localparam logic [20:0] ERR1_W =
    {3'd0, 3'd5, 3'd0, 3'd0, 3'd1, 3'd6, 3'd3};
  localparam logic [20:0] ERRL_W =
    {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd6, 3'd0};
  localparam logic [20:0] UNC_W =
    {3'd1, 3'd2, 3'd0, 3'd0, 3'd1, 3'd6, 3'd3};

  always #5 clk = ~clk;

  rs_t1_stream_decoder #(
    .M(3),
    .PRIM_POLY(4'b1011)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sym(in_sym),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sym(out_sym),
    .out_last(out_last),
    .out_corrected(out_corrected),
    .out_uncorrectable(out_uncorrectable)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // sink readiness: always, never, or random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // monitor: pop on every transfer, check holds while stalled
  logic       stall_prev = 1'b0;
  logic [5:0] held = '0;
  always @(negedge clk) begin
    logic [5:0] cur;
    cur = {out_sym, out_last, out_corrected, out_uncorrectable};
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'(cur), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected none", cur);
        end else begin
          chk("beat", 32'(cur), 32'(exp_q.pop_front()));
        end
      end
      stall_prev = out_valid && !out_ready;
      held = cur;
    end
  end

  task automatic push_exp(input logic [20:0] w, input logic c,
                          input logic u);
    for (int i = 0; i < 7; i++)
      exp_q.push_back({w[20-3*i -: 3], i == 6, c, u});
  endtask

  task automatic send(input logic [20:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      int budget;
      logic ok;
      budget = 0;
      in_valid = 1'b1;
      in_sym = w[20-3*i -: 3];
      do begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        budget++;
      end while (!ok && budget < 500);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready got 0 expected 1");
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d left expected 0",
               exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sym"}, 32'(out_sym), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_corr"}, 32'(out_corrected), 32'd0);
    chk({tag, "_unc"}, 32'(out_uncorrectable), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    push_exp(CLEAN_W, 1'b0, 1'b0);
    send(CLEAN_W, 7);
    @(negedge clk);
    chk("lat_t1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_t2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_t3", 32'(out_valid), 32'd1);
    wait_drain();

    push_exp(CLEAN_W, 1'b1, 1'b0);
    send(ERR1_W, 7);
    wait_drain();
    push_exp(CLEAN_W, 1'b1, 1'b0);
    send(ERRL_W, 7);
    wait_drain();
    push_exp(UNC_W, 1'b0, 1'b1);
    send(UNC_W, 7);
    wait_drain();

    rdy_mode = 1;
    @(posedge clk);
    #1;
    push_exp(CLEAN_W, 1'b0, 1'b0);
    push_exp(CLEAN_W, 1'b1, 1'b0);
    push_exp(CLEAN_W, 1'b1, 1'b0);
    send(CLEAN_W, 7);
    send(ERR1_W, 7);
    @(negedge clk);
    chk("full_ready_a", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("full_ready_b", 32'(in_ready), 32'd0);
    chk("full_stalled", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    fork
      send(ERRL_W, 7);
    join_none
    rdy_mode = 2;
    wait_drain();
    wait fork;
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    push_exp(CLEAN_W, 1'b0, 1'b0);
    send(CLEAN_W, 7);
    send(CLEAN_W, 3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid_reset_left", 32'(exp_q.size()), 32'd3);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk_idle("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    push_exp(CLEAN_W, 1'b0, 1'b0);
    send(CLEAN_W, 7);
    wait_drain();
    repeat (20) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
